// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the reduced RISC-V core: sequences fetch, decode,
// execute, memory and writeback one instruction at a time and counts retirements.
module multicycle_ctrl #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          instr,
   input  logic                 mem_ready,
   input  logic                 eq,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 mem_sel,
   output logic                 ir_we,
   output logic                 mdr_we,
   output logic                 pc_we,
   output logic                 pc_src,
   output logic                 reg_we,
   output logic [1:0]           wb_sel,
   output logic                 alusrc,
   output logic [2:0]           aluctrl,
   output logic                 illegal,
   output logic [CNT_WIDTH-1:0] instret
);

   typedef enum logic [2:0] {
      ST_RST    = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } state_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_W   = 3'b010;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MDR = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   typedef struct packed {
      logic       mem_req;
      logic       mem_sel;
      logic       mem_we;
      logic       pc_we;
      logic       pc_src;
      logic       reg_we;
      logic [1:0] wb_sel;
      logic       alusrc;
      logic [2:0] aluctrl;
      logic       illegal;
   } ctrl_t;

   state_t               state_r;
   state_t               state_nxt_s;
   ctrl_t                ctrl_r;
   ctrl_t                ctrl_nxt_s;
   logic [6:0]           op_r;
   logic [6:0]           op_nxt_s;
   logic [2:0]           f3_r;
   logic [2:0]           f3_nxt_s;
   logic                 f7b5_r;
   logic                 f7b5_nxt_s;
   logic [4:0]           rd_r;
   logic [4:0]           rd_nxt_s;
   logic [CNT_WIDTH-1:0] instret_r;
   logic                 is_load_s;
   logic                 is_store_s;
   logic                 hs_fetch_s;
   logic                 hs_mem_s;
   logic                 pc_we_s;
   logic                 pc_src_s;
   logic                 instr_unused_s;

   function automatic logic legal_op(input logic [6:0] op, input logic [2:0] f3);
      logic ok;
      case (op)
         OP_R, OP_I:   ok = (f3 == F3_ADD) || (f3 == F3_AND) || (f3 == F3_OR);
         OP_LW, OP_SW: ok = (f3 == F3_W);
         OP_BEQ:       ok = (f3 == 3'b000);
         OP_JAL:       ok = 1'b1;
         default:      ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
      logic [2:0] code;
      case (f3)
         F3_AND:  code = ALU_AND;
         F3_OR:   code = ALU_OR;
         default: code = sub ? ALU_SUB : ALU_ADD;
      endcase
      return code;
   endfunction

   // Moore part of the control word; the ALU settings of EXEC are repeated in WB
   // so that aluout stays valid while it is written back.
   function automatic ctrl_t moore_ctrl(input state_t st, input logic [6:0] op,
                                        input logic [2:0] f3, input logic f7b5,
                                        input logic [4:0] rd);
      ctrl_t      c;
      logic [2:0] code;
      c    = '0;
      code = alu_op(f3, (op == OP_R) && f7b5);
      case (st)
         ST_FETCH: c.mem_req = 1'b1;
         ST_EXEC: begin
            case (op)
               OP_R: c.aluctrl = code;
               OP_I: begin
                  c.alusrc  = 1'b1;
                  c.aluctrl = code;
               end
               OP_LW, OP_SW: c.alusrc = 1'b1;
               OP_BEQ: begin
                  c.aluctrl = ALU_SUB;
                  c.pc_we   = 1'b1;
               end
               OP_JAL: begin
                  c.pc_we  = 1'b1;
                  c.pc_src = 1'b1;
                  c.reg_we = 1'b1;
                  c.wb_sel = WB_PC4;
               end
               default: c = '0;
            endcase
         end
         ST_MEM: begin
            c.mem_req = 1'b1;
            c.mem_sel = 1'b1;
            c.mem_we  = (op == OP_SW);
            c.alusrc  = 1'b1;
         end
         ST_WB: begin
            c.reg_we = 1'b1;
            c.pc_we  = 1'b1;
            case (op)
               OP_LW: begin
                  c.wb_sel = WB_MDR;
                  c.alusrc = 1'b1;
               end
               OP_I: begin
                  c.alusrc  = 1'b1;
                  c.aluctrl = code;
               end
               OP_R:    c.aluctrl = code;
               default: c.wb_sel  = WB_ALU;
            endcase
         end
         ST_TRAP: c.illegal = 1'b1;
         default: c = '0;
      endcase
      if (rd == 5'd0) begin
         c.reg_we = 1'b0;
      end else begin
         c.reg_we = c.reg_we;
      end
      return c;
   endfunction

   assign instr_unused_s = ^{instr[31], instr[29:15]};

   // Qualified strobes that depend on the memory handshake or the ALU flag.
   always_comb begin
      is_load_s  = (op_r == OP_LW);
      is_store_s = (op_r == OP_SW);
      hs_fetch_s = (state_r == ST_FETCH) && mem_ready;
      hs_mem_s   = (state_r == ST_MEM) && mem_ready;
      pc_we_s    = ctrl_r.pc_we || (hs_mem_s && is_store_s);
      pc_src_s   = ctrl_r.pc_src || ((state_r == ST_EXEC) && (op_r == OP_BEQ) && eq);
   end

   // Next state, decode-field capture and the control word of the next state.
   always_comb begin
      state_nxt_s = state_r;
      op_nxt_s    = op_r;
      f3_nxt_s    = f3_r;
      f7b5_nxt_s  = f7b5_r;
      rd_nxt_s    = rd_r;
      case (state_r)
         ST_RST: state_nxt_s = ST_FETCH;
         ST_FETCH: begin
            if (mem_ready) begin
               state_nxt_s = ST_DECODE;
               op_nxt_s    = instr[6:0];
               f3_nxt_s    = instr[14:12];
               f7b5_nxt_s  = instr[30];
               rd_nxt_s    = instr[11:7];
            end else begin
               state_nxt_s = ST_FETCH;
            end
         end
         ST_DECODE: begin
            if (legal_op(op_r, f3_r)) begin
               state_nxt_s = ST_EXEC;
            end else begin
               state_nxt_s = ST_TRAP;
            end
         end
         ST_EXEC: begin
            case (op_r)
               OP_R, OP_I:     state_nxt_s = ST_WB;
               OP_LW, OP_SW:   state_nxt_s = ST_MEM;
               OP_BEQ, OP_JAL: state_nxt_s = ST_FETCH;
               default:        state_nxt_s = ST_TRAP;
            endcase
         end
         ST_MEM: begin
            if (!mem_ready) begin
               state_nxt_s = ST_MEM;
            end else if (is_load_s) begin
               state_nxt_s = ST_WB;
            end else begin
               state_nxt_s = ST_FETCH;
            end
         end
         ST_WB:   state_nxt_s = ST_FETCH;
         ST_TRAP: state_nxt_s = ST_TRAP;
         default: state_nxt_s = ST_RST;
      endcase
      ctrl_nxt_s = moore_ctrl(state_nxt_s, op_nxt_s, f3_nxt_s, f7b5_nxt_s, rd_nxt_s);
   end

   // State, latched decode fields and registered Moore control word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_RST;
         ctrl_r  <= '0;
         op_r    <= 7'd0;
         f3_r    <= 3'd0;
         f7b5_r  <= 1'b0;
         rd_r    <= 5'd0;
      end else begin
         state_r <= state_nxt_s;
         ctrl_r  <= ctrl_nxt_s;
         op_r    <= op_nxt_s;
         f3_r    <= f3_nxt_s;
         f7b5_r  <= f7b5_nxt_s;
         rd_r    <= rd_nxt_s;
      end
   end

   // Retired-instruction counter, one count per PC update, wrapping naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instret_r <= '0;
      end else if (pc_we_s) begin
         instret_r <= instret_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         instret_r <= instret_r;
      end
   end

   assign mem_req = ctrl_r.mem_req;
   assign mem_sel = ctrl_r.mem_sel;
   assign mem_we  = ctrl_r.mem_we;
   assign ir_we   = hs_fetch_s;
   assign mdr_we  = hs_mem_s && is_load_s;
   assign pc_we   = pc_we_s;
   assign pc_src  = pc_src_s;
   assign reg_we  = ctrl_r.reg_we;
   assign wb_sel  = ctrl_r.wb_sel;
   assign alusrc  = ctrl_r.alusrc;
   assign aluctrl = ctrl_r.aluctrl;
   assign illegal = ctrl_r.illegal;
   assign instret = instret_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is compared against an
// instruction-level model of latency, strobe counts, final controls and retire count.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

   localparam int CW    = 4;
   localparam int K_R   = 0;
   localparam int K_I   = 1;
   localparam int K_LW  = 2;
   localparam int K_SW  = 3;
   localparam int K_BEQ = 4;
   localparam int K_JAL = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   instr = 32'd0;
   logic          mem_ready = 1'b0;
   logic          eq = 1'b0;
   logic          mem_req, mem_we, mem_sel, ir_we, mdr_we, pc_we, pc_src, reg_we;
   logic [1:0]    wb_sel;
   logic          alusrc;
   logic [2:0]    aluctrl;
   logic          illegal;
   logic [CW-1:0] instret;
   logic [14:0]   outs;

   int tests = 0;
   int fails = 0;
   int model_cnt = 0;

   multicycle_ctrl #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .eq(eq),
      .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .ir_we(ir_we),
      .mdr_we(mdr_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
      .wb_sel(wb_sel), .alusrc(alusrc), .aluctrl(aluctrl), .illegal(illegal),
      .instret(instret)
   );

   assign outs = {mem_req, mem_we, mem_sel, ir_we, mdr_we, pc_we, pc_src, reg_we,
                  wb_sel, alusrc, aluctrl, illegal};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] gen_instr(input int k);
      logic [31:0] r;
      logic [31:0] w;
      logic [4:0]  rd;
      logic [2:0]  f3;
      r  = $urandom;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : r[11:7];
      case ($urandom_range(0, 2))
         0:       f3 = 3'b000;
         1:       f3 = 3'b111;
         default: f3 = 3'b110;
      endcase
      case (k)
         K_R:     w = {r[31:15], f3, rd, 7'b0110011};
         K_I:     w = {r[31:15], f3, rd, 7'b0010011};
         K_LW:    w = {r[31:15], 3'b010, rd, 7'b0000011};
         K_SW:    w = {r[31:15], 3'b010, r[11:7], 7'b0100011};
         K_BEQ:   w = {r[31:15], 3'b000, r[11:7], 7'b1100011};
         default: w = {r[31:12], rd, 7'b1101111};
      endcase
      return w;
   endfunction

   task automatic release_rst();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      chk("rst_first_cycle", {17'd0, outs}, 32'd0);
      model_cnt = 0;
   endtask

   // Runs one legal instruction with fw fetch waits, mw memory waits, branch flag eqv.
   task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic eqv);
      int k, lat, cyc, fw_cnt, mw_cnt, n_ir, n_mdr, n_reg, n_req0, n_req1, n_we;
      logic done, fetched, mem_op, writes;
      logic [2:0] exp_alu, fin_alu;
      logic [1:0] exp_wb, fin_wb;
      logic exp_src, fin_src, exp_pcsrc, fin_pcsrc, fin_reg;
      case (ins[6:0])
         7'b0110011: k = K_R;
         7'b0010011: k = K_I;
         7'b0000011: k = K_LW;
         7'b0100011: k = K_SW;
         7'b1100011: k = K_BEQ;
         default:    k = K_JAL;
      endcase
      mem_op = (k == K_LW) || (k == K_SW);
      lat    = ((k == K_LW) ? 5 : ((k == K_BEQ) || (k == K_JAL)) ? 3 : 4) + fw + (mem_op ? mw : 0);
      writes = (k inside {K_R, K_I, K_LW, K_JAL}) && (ins[11:7] != 5'd0);
      exp_wb = (k == K_LW) ? 2'b01 : (k == K_JAL) ? 2'b10 : 2'b00;
      if ((k == K_R) || (k == K_I)) begin
         if (ins[14:12] == 3'b111)            exp_alu = 3'b010;
         else if (ins[14:12] == 3'b110)       exp_alu = 3'b011;
         else if ((k == K_R) && ins[30])      exp_alu = 3'b001;
         else                                 exp_alu = 3'b000;
      end else begin
         exp_alu = (k == K_BEQ) ? 3'b001 : 3'b000;
      end
      exp_src   = (k == K_I) || mem_op;
      exp_pcsrc = (k == K_JAL) || ((k == K_BEQ) && eqv);
      cyc = 0; fw_cnt = 0; mw_cnt = 0; n_ir = 0; n_mdr = 0; n_reg = 0;
      n_req0 = 0; n_req1 = 0; n_we = 0; done = 1'b0; fetched = 1'b0;
      fin_alu = 3'd0; fin_wb = 2'd0; fin_src = 1'b0; fin_pcsrc = 1'b0; fin_reg = 1'b0;
      instr = ins;
      while (!done && (cyc < 40)) begin
         @(negedge clk);
         cyc++;
         if (fetched) instr = $urandom;
         eq = (k == K_BEQ) ? eqv : 1'($urandom_range(0, 1));
         if (mem_req && !mem_sel) begin
            mem_ready = (fw_cnt == fw);
            fw_cnt++;
         end else if (mem_req && mem_sel) begin
            mem_ready = (mw_cnt == mw);
            mw_cnt++;
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
         end
         #1;
         n_req0 += int'(mem_req && !mem_sel);
         n_req1 += int'(mem_req && mem_sel);
         n_we   += int'(mem_we);
         n_ir   += int'(ir_we);
         n_mdr  += int'(mdr_we);
         n_reg  += int'(reg_we);
         if (ir_we) fetched = 1'b1;
         if (pc_we) begin
            done      = 1'b1;
            fin_alu   = aluctrl;
            fin_wb    = wb_sel;
            fin_src   = alusrc;
            fin_pcsrc = pc_src;
            fin_reg   = reg_we;
         end
      end
      chk("retired", {31'd0, done}, 32'd1);
      chk("latency", cyc, lat);
      chk("ir_we_count", n_ir, 1);
      chk("mdr_we_count", n_mdr, (k == K_LW) ? 1 : 0);
      chk("reg_we_count", n_reg, writes ? 1 : 0);
      chk("fetch_req_cycles", n_req0, fw + 1);
      chk("mem_req_cycles", n_req1, mem_op ? mw + 1 : 0);
      chk("mem_we_cycles", n_we, (k == K_SW) ? mw + 1 : 0);
      chk("final_pc_src", {31'd0, fin_pcsrc}, {31'd0, exp_pcsrc});
      chk("final_aluctrl", {29'd0, fin_alu}, {29'd0, exp_alu});
      chk("final_alusrc", {31'd0, fin_src}, {31'd0, exp_src});
      chk("final_wb_sel", {30'd0, fin_wb}, {30'd0, exp_wb});
      chk("final_reg_we", {31'd0, fin_reg}, {31'd0, writes});
      @(posedge clk);
      #1;
      model_cnt++;
      chk("instret", {{(32-CW){1'b0}}, instret}, model_cnt % (1 << CW));
   endtask

   task automatic reset_mid_mem();
      int cyc, sel_cnt;
      cyc = 0; sel_cnt = 0;
      instr = 32'h0080A283;
      while ((sel_cnt < 2) && (cyc < 20)) begin
         @(negedge clk);
         cyc++;
         mem_ready = mem_req && !mem_sel;
         #1;
         if (mem_req && mem_sel) sel_cnt++;
      end
      chk("mid_mem_reached", sel_cnt, 2);
      rst_n = 1'b0;
      #1;
      chk("mid_mem_rst_outs", {17'd0, outs}, 32'd0);
      chk("mid_mem_rst_instret", {{(32-CW){1'b0}}, instret}, 32'd0);
      release_rst();
   endtask

   task automatic run_illegal(input logic [31:0] ins);
      int cyc, bad;
      logic hs;
      cyc = 0; bad = 0; hs = 1'b0;
      instr = ins;
      while (!hs && (cyc < 10)) begin
         @(negedge clk);
         cyc++;
         mem_ready = mem_req ? 1'b1 : 1'($urandom_range(0, 1));
         #1;
         if (ir_we) hs = 1'b1;
      end
      chk("ill_fetched", {31'd0, hs}, 32'd1);
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      chk("ill_decode_flag", {31'd0, illegal}, 32'd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         mem_ready = 1'($urandom_range(0, 1));
         eq        = 1'($urandom_range(0, 1));
         instr     = $urandom;
         #1;
         if (!illegal) bad++;
         if (mem_req || mem_we || ir_we || mdr_we || pc_we || reg_we) bad++;
      end
      chk("trap_quiet", bad, 0);
      chk("trap_instret", {{(32-CW){1'b0}}, instret}, model_cnt % (1 << CW));
      rst_n = 1'b0;
      #1;
      chk("trap_rst_illegal", {31'd0, illegal}, 32'd0);
      chk("trap_rst_instret", {{(32-CW){1'b0}}, instret}, 32'd0);
      release_rst();
   endtask

   initial begin
      #2;
      chk("rst_outs", {17'd0, outs}, 32'd0);
      chk("rst_instret", {{(32-CW){1'b0}}, instret}, 32'd0);
      release_rst();
      run_instr(32'h002081B3, 0, 0, 1'b0);
      run_instr(32'h0080A283, 0, 3, 1'b0);
      run_instr(32'h00208063, 0, 0, 1'b1);
      run_instr(32'h00208063, 0, 0, 1'b0);
      run_instr(32'h40208033, 0, 0, 1'b0);
      run_instr(32'h0020E233, 0, 0, 1'b0);
      for (int i = 0; i < 60; i++) begin
         run_instr(gen_instr($urandom_range(0, 5)), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      reset_mid_mem();
      for (int i = 0; i < 10; i++) begin
         run_instr(gen_instr($urandom_range(0, 5)), $urandom_range(0, 2),
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end
      run_illegal(32'hFFFFFFFF);
      run_illegal(32'h0020A033);
      run_illegal(32'h00008283);
      run_illegal(32'h00209063);
      for (int i = 0; i < 20; i++) begin
         run_instr(gen_instr($urandom_range(0, 5)), $urandom_range(0, 1),
                   $urandom_range(0, 1), 1'($urandom_range(0, 1)));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the reduced RISC-V core. It sequences the shared ALU, the single memory port, the instruction register, the PC and the register file through the fetch, decode, execute, memory and writeback phases, one instruction at a time. It drives the ALU's `alusrc`/`aluctrl` and consumes its `eq` flag. It also counts retired instructions.

## Interface
Parameters:
- `CNT_WIDTH`, default 32: width of the retired-instruction counter.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `instr`, in, 32: memory read data; holds the fetched instruction while `mem_ready` is high in FETCH.
- `mem_ready`, in, 1: memory handshake completion.
- `eq`, in, 1: ALU equality flag.
- `mem_req`, out, 1: memory request.
- `mem_we`, out, 1: memory write; store only.
- `mem_sel`, out, 1: memory address select. 0 = PC, 1 = `aluout`.
- `ir_we`, out, 1: instruction register load.
- `mdr_we`, out, 1: memory data register load.
- `pc_we`, out, 1: PC update.
- `pc_src`, out, 1: PC source. 0 = PC+4, 1 = PC+imm.
- `reg_we`, out, 1: register file write.
- `wb_sel`, out, 2: writeback source. 00 = `aluout`, 01 = MDR, 10 = PC+4.
- `alusrc`, out, 1: ALU operand-2 select, as consumed by the ALU.
- `aluctrl`, out, 3: ALU operation. 000 add, 001 sub, 010 and, 011 or.
- `illegal`, out, 1: sticky flag for an undecodable instruction.
- `instret`, out, CNT_WIDTH: retired-instruction count.

## Operation
- **Decode latch.** On a FETCH handshake, an internal copy of opcode[6:0], funct3, funct7[5] and rd is latched in the same cycle as `ir_we`.
- **Supported instructions:**
  - R-type `0110011`: add (f3 000, f7b5 0), sub (f3 000, f7b5 1), and (f3 111), or (f3 110).
  - I-ALU `0010011`: addi (000), andi (111), ori (110).
  - lw: `0000011`, f3 010.
  - sw: `0100011`, f3 010.
  - beq: `1100011`, f3 000.
  - jal: `1101111`.
  - Anything else is illegal.
- **Output model.** All outputs are Moore decodes of state and the latched fields, except the `mem_ready` and `eq` qualified strobes listed below. Outputs not listed for a state are 0.
- **States:**
  - RST: all outputs 0. Next state FETCH, unconditionally.
  - FETCH: `mem_req`=1, `mem_sel`=0. When `mem_ready`=1: `ir_we`=1 and next state DECODE. Otherwise stay in FETCH.
  - DECODE: one cycle. Illegal → TRAP; otherwise → EXEC.
  - EXEC, ALU ops: `alusrc` = 0 (R) or 1 (I); `aluctrl` from funct3/f7b5. Next state WB.
  - EXEC, lw/sw: `alusrc`=1, `aluctrl`=000. Next state MEM.
  - EXEC, beq: `alusrc`=0, `aluctrl`=001, `pc_we`=1, `pc_src`=`eq`. Next state FETCH.
  - EXEC, jal: `pc_we`=1, `pc_src`=1, `reg_we`=1, `wb_sel`=10. Next state FETCH.
  - MEM: `mem_req`=1, `mem_sel`=1, `mem_we` = store, `alusrc`=1, `aluctrl`=000 held.
    - When `mem_ready`=1 on a load: `mdr_we`=1, next state WB.
    - When `mem_ready`=1 on a store: `pc_we`=1, `pc_src`=0, next state FETCH.
  - WB: `reg_we`=1, `wb_sel` = 00 (ALU op) or 01 (lw), `pc_we`=1, `pc_src`=0. The ALU controls from EXEC are held so `aluout` stays valid. Next state FETCH.
  - TRAP: `illegal`=1, all enables 0. Stays in TRAP until reset.
- **rd = x0.** `reg_we` is suppressed (forced 0) whenever the latched rd = 0, in every state.
- **Retire counter.** `instret` increments by 1 on every cycle with `pc_we`=1. It wraps from all-ones to 0.

## Timing
- **Reset.** `rst_n` low forces, immediately and asynchronously: state RST, all outputs 0, `illegal`=0, `instret`=0, decode fields 0.
  - The first `mem_req` appears in the second cycle after `rst_n` rises (RST then FETCH).
  - Reset mid-instruction, including during an outstanding memory wait, abandons the instruction and returns to RST.
- **Latency with zero-wait memory** (`mem_ready` high in the first request cycle):
  - R/I: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, jal: 3 cycles.
  - Each memory wait cycle adds 1.
- **Memory handshake.**
  - `mem_req`, `mem_sel` and `mem_we` stay stable until the cycle in which `mem_ready`=1. That cycle completes the transfer.
  - `mem_req` deasserts in the following cycle.
  - `mem_ready` is ignored outside FETCH and MEM.
- **Branch.** `eq` is sampled only in EXEC for beq.
- **Retire timing.** `instret` updates on the clock edge that ends the `pc_we` cycle.

## Test plan
- **Reset and straight-line ALU.** Reset, then fetch `add x3,x1,x2` (0x002081B3) with zero-wait memory:
  - `mem_req` first asserts in cycle 2 after reset release.
  - WB has `reg_we`=1, `wb_sel`=00, `aluctrl`=000.
  - `instret`=1 after 4 cycles.
- **Load with memory stall.** Load `lw x5,8(x1)` with `mem_ready` held low for 3 cycles in MEM:
  - `mem_req`/`mem_sel`=1 stay stable throughout the stall.
  - `mdr_we` pulses once; WB has `wb_sel`=01.
  - Total of 8 cycles.
- **Branch both ways.**
  - `beq` with `eq`=1 → `pc_src`=1, `pc_we`=1 in EXEC.
  - `beq` with `eq`=0 → `pc_src`=0.
  - Both complete in 3 cycles.
- **x0 suppression and sub/or.**
  - `sub x0,x1,x2` → `aluctrl`=001 and `reg_we`=0 throughout.
  - `or x4,x1,x2` → `aluctrl`=011 and `reg_we`=1 in WB.
- **Illegal and reset recovery.** Fetch 0xFFFFFFFF:
  - `illegal`=1 from TRAP onward, and no enables thereafter for 20 cycles.
  - Assert `rst_n` low mid-TRAP → `illegal`=0 immediately.
- **Counter wrap.** Force `instret` to all-ones (or use CNT_WIDTH=4 and run 16 instructions) → the count wraps to 0 after the next retire.
